// File: rtl/somador_pkg.sv
// Shared definitions for the serial nibble adder: FSM state encoding,
// default operand size and nibble width.
package somador_pkg;

  // Controller states: idle, nibble loop, publish result.
  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    SOMA   = 2'd1,
    FIM    = 2'd2
  } estado_t;

  localparam int NIBBLES_DEF = 4;
  localparam int NIB_W       = 4;

endpackage

// File: rtl/somador4bits.sv
// Purely combinational 4-bit adder with carry in/out, shared by the
// serial controller for every nibble of a wide addition.
module somador4bits
  import somador_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  // Zero-extend every term so the fifth bit carries the nibble's carry-out.
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};

endmodule

// File: rtl/somador_serial_ctrl.sv
// Serial wide adder: latches A/B/cin on a start request, then pushes one
// nibble pair per clock (LSB first) through a single somador4bits,
// collecting the partial sums and publishing {cout, s} with a done pulse.
// Optional signed-overflow output is built when SOMADOR_OVF_EN is defined.
module somador_serial_ctrl
  import somador_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inicio,
  input  logic [NIB_W*NIBBLES-1:0] a,
  input  logic [NIB_W*NIBBLES-1:0] b,
  input  logic                   cin,
  output logic                   ocupado,
  output logic                   pronto,
  output logic [NIB_W*NIBBLES-1:0] s,
  output logic                   cout
`ifdef SOMADOR_OVF_EN
  ,
  output logic                   ovf
`endif
);

  localparam int W  = NIB_W * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  estado_t          estado, estado_nx;
  logic [IW-1:0]    idx;
  logic [W-1:0]     op_a, op_b;
  logic [W-1:0]     acc, acc_nx;
  logic             carry;
  logic             ultimo;
  logic [NIB_W-1:0] nib_a, nib_b, nib_s;
  logic             nib_cout;

  assign nib_a   = op_a[idx*NIB_W +: NIB_W];
  assign nib_b   = op_b[idx*NIB_W +: NIB_W];
  assign ultimo  = (idx == IW'(NIBBLES - 1));
  assign ocupado = (estado != OCIOSO);
  assign pronto  = (estado == FIM);

  somador4bits u_somador (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .s    (nib_s),
    .cout (nib_cout)
  );

  // Next state and the accumulator image with the current nibble merged in.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    estado_nx = estado;
    acc_nx    = acc;
    acc_nx[idx*NIB_W +: NIB_W] = nib_s;
    case (estado)
      OCIOSO:  if (inicio) estado_nx = SOMA;
      SOMA:    if (ultimo) estado_nx = FIM;
      FIM:     estado_nx = OCIOSO;
      default: estado_nx = OCIOSO;
    endcase
  end

  // State register, operand capture, nibble loop and result publication.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      estado <= OCIOSO;
      idx    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      s      <= '0;
      cout   <= 1'b0;
`ifdef SOMADOR_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      estado <= estado_nx;
      case (estado)
        OCIOSO: begin
          if (inicio) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            idx   <= '0;
          end
        end
        SOMA: begin
          acc   <= acc_nx;
          carry <= nib_cout;
          idx   <= ultimo ? '0 : idx + 1'b1;
          if (ultimo) begin
            // Publish on the edge entering FIM, final nibble included.
            s    <= acc_nx;
            cout <= nib_cout;
`ifdef SOMADOR_OVF_EN
            ovf  <= (op_a[W-1] == op_b[W-1]) && (nib_s[NIB_W-1] != op_a[W-1]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_somador_serial_ctrl.sv
// Self-checking bench for somador_serial_ctrl (NIBBLES=4): table of
// hand-computed sums plus directed sequences for interference, mid-run
// reset, reset/start collision and back-to-back starts.
module tb_somador_serial_ctrl;
  import somador_pkg::*;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, inicio, cin;
  logic [W-1:0] a, b, s;
  logic         ocupado, pronto, cout;
`ifdef SOMADOR_OVF_EN
  logic         ovf;
`endif

  somador_serial_ctrl #(.NIBBLES(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .inicio  (inicio),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .ocupado (ocupado),
    .pronto  (pronto),
    .s       (s),
    .cout    (cout)
`ifdef SOMADOR_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    string        name;
  } vec_t;

  vec_t         vecs[8];
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] prev_s;
  logic         prev_cout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Run one operation; optionally disturb inputs and pulse inicio while busy.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                        input logic [W-1:0] es, input logic ec, input logic eo,
                        input bit interfere, input string tag);
    int pr_cnt = 0;
    int pr_cyc = 0;
    int oc_cnt = 0;
    @(negedge clk);
    a = va; b = vb; cin = vc; inicio = 1'b1;
    for (int c = 1; c <= N + 4; c++) begin
      @(negedge clk);
      if (pronto) begin pr_cnt++; pr_cyc = c; end
      if (ocupado) oc_cnt++;
      if (c == N) begin
        check({tag, "_s_held"}, 32'(s), 32'(prev_s));
        check({tag, "_cout_held"}, 32'(cout), 32'(prev_cout));
      end
      if (c == 1) inicio = 1'b0;
      if (interfere) begin
        if (c == 2)     begin a = ~va; b = ~vb; cin = ~vc; inicio = 1'b1; end
        if (c == 3)     inicio = 1'b0;
        if (c == N + 1) inicio = 1'b1;
        if (c == N + 2) inicio = 1'b0;
      end
    end
    check({tag, "_pronto_count"}, 32'(pr_cnt), 32'd1);
    check({tag, "_pronto_cycle"}, 32'(pr_cyc), 32'(N + 1));
    check({tag, "_ocupado_cycles"}, 32'(oc_cnt), 32'(N + 1));
    check({tag, "_s"}, 32'(s), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
`ifdef SOMADOR_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("note: undefined ovf expectation in %s", tag);
`endif
    prev_s    = es;
    prev_cout = ec;
  endtask

  initial begin
    int pr_cnt;

    vecs[0] = '{16'h1234, 16'h0F0F, 1'b0, 16'h2143, 1'b0, 1'b0, "v_basic"};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "v_ripple"};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, "v_cin"};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "v_ovf_pos"};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "v_ovf_neg"};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, "v_allones"};
    vecs[6] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, "v_ovf_top"};
    vecs[7] = '{16'h9999, 16'h6667, 1'b0, 16'h0000, 1'b1, 1'b0, "v_chain"};

    rst = 1'b1; inicio = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ocupado", 32'(ocupado), 32'd0);
    check("rst_pronto", 32'(pronto), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
`ifdef SOMADOR_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;
    prev_s = '0; prev_cout = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].cout, vecs[i].ovf,
             1'b0, vecs[i].name);

    // Inputs change and inicio pulses during SOMA and FIM: original operands win.
    run_op(16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0, 1'b1, "interfere");

    // Reset during the second SOMA cycle aborts the operation.
    @(negedge clk);
    a = 16'h5555; b = 16'h2222; cin = 1'b0; inicio = 1'b1;
    pr_cnt = 0;
    for (int c = 1; c <= N + 4; c++) begin
      @(negedge clk);
      if (pronto) pr_cnt++;
      if (c == 3) begin
        check("abort_ocupado", 32'(ocupado), 32'd0);
        check("abort_s", 32'(s), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        rst = 1'b0;
      end
      if (c == 1) inicio = 1'b0;
      if (c == 2) rst = 1'b1;
    end
    check("abort_no_pronto", 32'(pr_cnt), 32'd0);
    prev_s = '0; prev_cout = 1'b0;
    run_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, "after_abort");

    // Reset and start together: reset wins, no operation starts.
    @(negedge clk);
    a = 16'h0005; b = 16'h0006; rst = 1'b1; inicio = 1'b1;
    @(negedge clk);
    rst = 1'b0; inicio = 1'b0;
    check("rst_win_ocupado", 32'(ocupado), 32'd0);
    check("rst_win_s", 32'(s), 32'd0);
    @(negedge clk);
    check("rst_win_idle", 32'(ocupado), 32'd0);

    // inicio held high: accepts at edges 1 and 7, done pulses after 5 and 11.
    a = 16'h0001; b = 16'h0002; cin = 1'b0; inicio = 1'b1;
    pr_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (pronto) pr_cnt++;
      if (c == 6) check("b2b_gap_idle", 32'(ocupado), 32'd0);
      if (c == 7) check("b2b_restart", 32'(ocupado), 32'd1);
      if (c == 12) inicio = 1'b0;
    end
    check("b2b_pronto_count", 32'(pr_cnt), 32'd2);
    check("b2b_s", 32'(s), 32'h0003);
    check("b2b_end_idle", 32'(ocupado), 32'd0);
    @(negedge clk);
    check("b2b_no_third", 32'(ocupado), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/somador_serial_ctrl.md
# somador_serial_ctrl

Multi-cycle sequencer that adds two wide operands using a single shared `somador4bits` nibble adder, one nibble per clock, least-significant first. It latches the operands on a start request and routes nibble pairs plus the running carry through the adder. It stores each 4-bit partial sum and presents the full result with a one-cycle completion pulse. It sits between a requesting datapath and the `somador4bits` instance it owns, so wide additions need no wide adder.

## Interface
Parameters:
- `NIBBLES`, default 4: number of 4-bit nibbles per operand; operand width `W = 4*NIBBLES`; legal range 2..8.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `inicio`  in  1: start request, sampled only in idle.
- `a`  in  W: operand A, captured on accepted start.
- `b`  in  W: operand B, captured on accepted start.
- `cin`  in  1: carry-in, captured on accepted start.
- `ocupado`  out  1: busy; high whenever the block is not idle.
- `pronto`  out  1: done; one-cycle pulse when `s`/`cout` are updated.
- `s`  out  W: sum of the last completed operation; holds until the next completion.
- `cout`  out  1: carry-out of the last completed operation.
- `ovf`  out  1: signed overflow of the last completed operation; present only with `SOMADOR_OVF_EN`.

## Operation
- States: `OCIOSO` (idle), `SOMA` (nibble loop), `FIM` (publish).
- `OCIOSO` with `inicio`=1: latch `a`, `b`, `cin` into internal registers; set nibble index `idx`=0; set carry register to `cin`; go to `SOMA`.
- `SOMA`: the adder receives nibble `idx` of the latched A and B, plus the carry register. On each edge:
  - the adder's `s` is written to accumulator nibble `idx`;
  - the adder's `cout` is written to the carry register;
  - `idx` increments.
  - After `idx`=NIBBLES-1, go to `FIM`. On that same edge, load `s` from the accumulator (including the final nibble) and `cout` from the final adder carry.
- `FIM`: `pronto`=1 for this cycle only; next edge goes to `OCIOSO`.
- `inicio` is ignored while `ocupado`=1 (states `SOMA` and `FIM`). No queueing.
- Arithmetic: result is {cout, s} = a + b + cin, modulo 2^(W+1). Fully unsigned carry chain.
- Latched operands are immune to changes on `a`/`b`/`cin` after acceptance.

## Timing
- Reset values: state `OCIOSO`, `idx`=0, `ocupado`=0, `pronto`=0, `s`=0, `cout`=0, `ovf`=0, accumulator and carry register 0.
- Start accepted at edge k. `SOMA` runs from edge k through edge k+NIBBLES. `FIM` holds during the cycle after edge k+NIBBLES; `pronto` is high in that cycle. The block returns to `OCIOSO` at edge k+NIBBLES+1.
- Latency: `pronto` is asserted NIBBLES+1 cycles after the accepting edge; `ocupado` stays high for NIBBLES+1 cycles.
- The earliest next accepted start is edge k+NIBBLES+2. Maximum throughput is one operation per NIBBLES+2 cycles.
- `s`, `cout` and `ovf` change only on the edge that enters `FIM`. They are stable at all other times.
- Reset mid-operation: the operation is aborted, no `pronto` is emitted, and all reset values apply on the next edge.
- `rst` and `inicio` high together: reset wins and the start is discarded.
- `inicio` held high continuously: a new operation is accepted each time the block is in `OCIOSO`.

## Configuration
- `SOMADOR_OVF_EN` defined: output `ovf` exists and is registered on entry to `FIM`.
  - `ovf` = (A[W-1]==B[W-1]) && (sum[W-1]!=A[W-1]), using the latched operands.
  - Reset value of `ovf` is 0.
- `SOMADOR_OVF_EN` undefined: no `ovf` port and no overflow logic. All other behaviour is identical.

## Structure
- Shared package `somador_pkg`: state encodings `OCIOSO`/`SOMA`/`FIM` (2-bit), default `NIBBLES`, and the nibble width constant (4).
- One sub-module: `somador4bits`, instantiated once, purely combinational (ports `a`, `b`, `cin`, `s`, `cout`).
- The controller contains only the FSM, index counter, operand/carry registers and the result accumulator.

## Test plan
Unless stated otherwise, tests use NIBBLES=4.
- a=0x1234, b=0x0F0F, cin=0 -> s=0x2143, cout=0. `pronto` fires exactly 5 cycles after the accepting edge. `ocupado` is high for 5 cycles.
- a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1. This checks full carry propagation across all nibbles.
- a=0x0000, b=0x0000, cin=1 -> s=0x0001, cout=0.
- With `SOMADOR_OVF_EN`:
  - a=0x7FFF, b=0x0001 -> s=0x8000, ovf=1, cout=0.
  - a=0x8000, b=0x8000 -> s=0x0000, ovf=1, cout=1.
- Change `a`/`b` and pulse `inicio` during `SOMA` -> the result matches the originally latched operands, only one `pronto` is emitted, and the second request is not queued.
- Assert `rst` at the 2nd `SOMA` cycle -> no `pronto`. `s`=0, `cout`=0 and `ocupado`=0 after the reset edge. The next start completes normally.
